// File: rtl/jk_reg_bank.sv
// WIDTH-channel JK register bank with clear/preset, load, up-count and shift-left modes.
// Define JK_BANK_CHANGE_FLAG_EN to add the registered 'changed' output.
module jk_reg_bank #(
  parameter int              WIDTH      = 4,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             preset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_not,
  output logic             tc,
`ifdef JK_BANK_CHANGE_FLAG_EN
  output logic             changed,
`endif
  output logic             sout
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;
  localparam logic [1:0] MODE_SHIFT = 2'b11;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic             sout_next;

  // Priority: clear > preset > !en > mode. Disabled edges and non-count modes drop tc.
  always_comb begin
    q_next    = q;
    tc_next   = 1'b0;
    sout_next = sout;
    if (clear) begin
      q_next    = '0;
      sout_next = 1'b0;
    end else if (preset) begin
      q_next    = PRESET_VAL;
      sout_next = 1'b0;
    end else if (en) begin
      case (mode)
        // JK characteristic equation applied bitwise
        MODE_JK:    q_next = (q & ~k) | (~q & j);
        MODE_LOAD:  q_next = d;
        MODE_COUNT: begin
          q_next  = q + ONE;
          tc_next = &q;
        end
        MODE_SHIFT: begin
          q_next    = {q[WIDTH-2:0], sin};
          sout_next = q[WIDTH-1];
        end
        default:    q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      q    <= '0;
      tc   <= 1'b0;
      sout <= 1'b0;
    end else begin
      q    <= q_next;
      tc   <= tc_next;
      sout <= sout_next;
    end
  end

`ifdef JK_BANK_CHANGE_FLAG_EN
  always_ff @(posedge clk) begin
    if (clear) changed <= 1'b0;
    else       changed <= (q_next != q);
  end
`endif

  assign q_not = ~q;

endmodule
